// File: rtl/add_bist_pkg.sv
// Shared types and the golden reference for the add_bist self-test engine.
// Optional capture ports in add_bist are enabled by defining ADD_BIST_CAPTURE_EN.
package add_bist_pkg;

    // Widest adder the golden function supports; the engine's W must not exceed this.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_e;

    // Full-width sum: the carry lands in bit MAX_W, so nothing is truncated.
    function automatic logic [MAX_W:0] golden_sum(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/add_bist_settle_cnt.sv
// Loadable down-counter: after a load, expire asserts on the SETTLE-th enabled cycle.
module add_bist_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/add_bist.sv
// Exhaustive self-test engine for a W-bit adder: sweeps every {a,b,cin} and counts mismatches.
// Define ADD_BIST_CAPTURE_EN to add fail_vec/fail_rsp capture of the first mismatch.
module add_bist
    import add_bist_pkg::*;
#(
    parameter int W      = 1,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    output logic             dut_cin,
    input  logic [W-1:0]     dut_s,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2*W:0]     vec_idx
`ifdef ADD_BIST_CAPTURE_EN
    ,
    output logic [2*W:0]     fail_vec,
    output logic [W:0]       fail_rsp
`endif
);

    localparam int VEC_W = 2 * W + 1;
    localparam logic [VEC_W-1:0] VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_idx_q, vec_idx_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             settle_load;
    logic             settle_en;
    logic             settle_expire;

    logic [W-1:0]     op_a, op_b;
    logic             op_cin;
    logic             drive_en;
    logic [W:0]       rsp;
    logic [MAX_W:0]   expected_full, observed_full;
    logic             mismatch;

`ifdef ADD_BIST_CAPTURE_EN
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
    logic [W:0]       fail_rsp_q, fail_rsp_d;
`endif

    assign op_a   = vec_idx_q[2*W:W+1];
    assign op_b   = vec_idx_q[W:1];
    assign op_cin = vec_idx_q[0];

    assign rsp           = {dut_cout, dut_s};
    assign expected_full = golden_sum(MAX_W'(op_a), MAX_W'(op_b), op_cin);
    assign observed_full = (MAX_W + 1)'(rsp);
    assign mismatch      = (expected_full != observed_full);

    assign settle_en = (state_q == DRIVE);

    add_bist_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (settle_load),
        .en     (settle_en),
        .expire (settle_expire)
    );

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        err_cnt_d   = err_cnt_q;
        settle_load = 1'b0;
`ifdef ADD_BIST_CAPTURE_EN
        fail_vec_d  = fail_vec_q;
        fail_rsp_d  = fail_rsp_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_idx_d   = '0;
                    err_cnt_d   = '0;
                    settle_load = 1'b1;
                    state_d     = DRIVE;
`ifdef ADD_BIST_CAPTURE_EN
                    fail_vec_d  = '0;
                    fail_rsp_d  = '0;
`endif
                end
            end
            DRIVE: begin
                if (settle_expire) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
`ifdef ADD_BIST_CAPTURE_EN
                    // A zero count means this is the first mismatch of the sweep.
                    if (err_cnt_q == '0) begin
                        fail_vec_d = vec_idx_q;
                        fail_rsp_d = rsp;
                    end
`endif
                end
                if (vec_idx_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    vec_idx_d   = vec_idx_q + VEC_W'(1);
                    settle_load = 1'b1;
                    state_d     = DRIVE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vec_idx_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef ADD_BIST_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_vec_q <= '0;
            fail_rsp_q <= '0;
        end else begin
            fail_vec_q <= fail_vec_d;
            fail_rsp_q <= fail_rsp_d;
        end
    end

    assign fail_vec = fail_vec_q;
    assign fail_rsp = fail_rsp_q;
`endif

    // Outputs decode straight from reset flops, so an async reset clears them without a clock.
    assign drive_en = (state_q == DRIVE) || (state_q == CHECK);
    assign dut_a    = drive_en ? op_a   : '0;
    assign dut_b    = drive_en ? op_b   : '0;
    assign dut_cin  = drive_en ? op_cin : 1'b0;
    assign busy     = drive_en;
    assign done     = (state_q == DONE);
    assign pass     = done && (err_cnt_q == '0);
    assign err_cnt  = err_cnt_q;
    assign vec_idx  = vec_idx_q;

endmodule

// File: tb/tb_add_bist.sv
// Self-checking bench for add_bist: two instances (W=1/SETTLE=1 and W=2/SETTLE=3/ERR_W=2)
// driven by a fault-injectable adder model, checked every cycle against a sweep-level reference.
module tb_add_bist;

    localparam int W0 = 1, S0 = 1, E0 = 8;
    localparam int W1 = 2, S1 = 3, E1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic [W0-1:0] a0, b0, s0;
    logic          cin0, cout0, busy0, done0, pass0;
    logic [E0-1:0] err0;
    logic [2*W0:0] vec0;

    logic [W1-1:0] a1, b1, s1;
    logic          cin1, cout1, busy1, done1, pass1;
    logic [E1-1:0] err1;
    logic [2*W1:0] vec1;

`ifdef ADD_BIST_CAPTURE_EN
    logic [2*W0:0] fv0;
    logic [W0:0]   fr0;
    logic [2*W1:0] fv1;
    logic [W1:0]   fr1;
`endif

    // Adder fault controls (live) and their snapshot taken when a sweep is accepted.
    int and_m[2];
    int xor_m[2];
    int and_s[2];
    int xor_s[2];
    int k[2];          // cycles since the accepted start edge; -1 after reset

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Faulty adder: true sum, then stuck-at-0 bits via and-mask, inverted bits via xor-mask.
    assign {cout0, s0} = (W0 + 1)'(((int'(a0) + int'(b0) + int'(cin0)) & and_m[0]) ^ xor_m[0]);
    assign {cout1, s1} = (W1 + 1)'(((int'(a1) + int'(b1) + int'(cin1)) & and_m[1]) ^ xor_m[1]);

    add_bist #(.W(W0), .SETTLE(S0), .ERR_W(E0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .dut_a    (a0),
        .dut_b    (b0),
        .dut_cin  (cin0),
        .dut_s    (s0),
        .dut_cout (cout0),
        .busy     (busy0),
        .done     (done0),
        .pass     (pass0),
        .err_cnt  (err0),
        .vec_idx  (vec0)
`ifdef ADD_BIST_CAPTURE_EN
        ,
        .fail_vec (fv0),
        .fail_rsp (fr0)
`endif
    );

    add_bist #(.W(W1), .SETTLE(S1), .ERR_W(E1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .dut_a    (a1),
        .dut_b    (b1),
        .dut_cin  (cin1),
        .dut_s    (s1),
        .dut_cout (cout1),
        .busy     (busy1),
        .done     (done1),
        .pass     (pass1),
        .err_cnt  (err1),
        .vec_idx  (vec1)
`ifdef ADD_BIST_CAPTURE_EN
        ,
        .fail_vec (fv1),
        .fail_rsp (fr1)
`endif
    );

    // ---------------- reference model ----------------
    function automatic int pw(int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic int ps(int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic int pe(int i);
        return (i == 0) ? E0 : E1;
    endfunction

    function automatic int tot(int i);
        return (1 << (2 * pw(i) + 1)) * (ps(i) + 1);
    endfunction

    function automatic int sum_of(int i, int v);
        int w;
        w = pw(i);
        return (v >> (w + 1)) + ((v >> 1) & ((1 << w) - 1)) + (v & 1);
    endfunction

    function automatic int rsp_of(int i, int v);
        return (sum_of(i, v) & and_s[i]) ^ xor_s[i];
    endfunction

    function automatic int full_mask(int i);
        return (1 << (pw(i) + 1)) - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k[0] <= -1;
            k[1] <= -1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (((i == 0) ? start0 : start1) && (k[i] < 0 || k[i] >= tot(i))) begin
                    k[i]     <= 0;
                    and_s[i] <= and_m[i];
                    xor_s[i] <= xor_m[i];
                end else if (k[i] >= 0 && k[i] < tot(i)) begin
                    k[i] <= k[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_inst(input int i, input int busy, input int done, input int pass,
                                input int err, input int vec, input int a, input int b,
                                input int cin, input int fv, input int fr, input bit has_cap);
        int e_busy, e_done, e_vec, e_a, e_b, e_cin, e_err, e_fv, e_fr;
        int n_chk, w, nv, cnt, first;
        string p;
        w  = pw(i);
        nv = 1 << (2 * w + 1);
        e_busy = 0; e_done = 0; e_vec = 0; e_a = 0; e_b = 0; e_cin = 0;
        n_chk = 0;
        if (k[i] >= 0 && k[i] < tot(i)) begin
            e_busy = 1;
            e_vec  = k[i] / (ps(i) + 1);
            e_a    = e_vec >> (w + 1);
            e_b    = (e_vec >> 1) & ((1 << w) - 1);
            e_cin  = e_vec & 1;
            n_chk  = e_vec;
        end else if (k[i] >= tot(i)) begin
            e_done = 1;
            e_vec  = nv - 1;
            n_chk  = nv;
        end
        cnt = 0;
        first = -1;
        for (int v = 0; v < n_chk; v++) begin
            if (rsp_of(i, v) != sum_of(i, v)) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
        e_err = (cnt > (1 << pe(i)) - 1) ? (1 << pe(i)) - 1 : cnt;
        e_fv  = (first < 0) ? 0 : first;
        e_fr  = (first < 0) ? 0 : rsp_of(i, first);
        p = $sformatf("u%0d", i);
        check({p, ".busy"},    busy, e_busy);
        check({p, ".done"},    done, e_done);
        check({p, ".pass"},    pass, (e_done != 0 && e_err == 0) ? 1 : 0);
        check({p, ".err_cnt"}, err,  e_err);
        check({p, ".vec_idx"}, vec,  e_vec);
        check({p, ".dut_a"},   a,    e_a);
        check({p, ".dut_b"},   b,    e_b);
        check({p, ".dut_cin"}, cin,  e_cin);
        if (has_cap) begin
            check({p, ".fail_vec"}, fv, e_fv);
            check({p, ".fail_rsp"}, fr, e_fr);
        end
    endtask

    // Single compare process: every falling edge, both instances against the model.
    always @(negedge clk) begin
`ifdef ADD_BIST_CAPTURE_EN
        compare_inst(0, int'(busy0), int'(done0), int'(pass0), int'(err0), int'(vec0),
                     int'(a0), int'(b0), int'(cin0), int'(fv0), int'(fr0), 1'b1);
        compare_inst(1, int'(busy1), int'(done1), int'(pass1), int'(err1), int'(vec1),
                     int'(a1), int'(b1), int'(cin1), int'(fv1), int'(fr1), 1'b1);
`else
        compare_inst(0, int'(busy0), int'(done0), int'(pass0), int'(err0), int'(vec0),
                     int'(a0), int'(b0), int'(cin0), 0, 0, 1'b0);
        compare_inst(1, int'(busy1), int'(done1), int'(pass1), int'(err1), int'(vec1),
                     int'(a1), int'(b1), int'(cin1), 0, 0, 1'b0);
`endif
    end

    // ---------------- stimulus ----------------
    function automatic bit is_done(int i);
        return (i == 0) ? done0 : done1;
    endfunction

    task automatic set_start(input int i, input logic v);
        if (i == 0) start0 = v;
        else        start1 = v;
    endtask

    // Pulses start, then counts edges until done. extra_at re-pulses start mid-sweep;
    // abort_at (instance 0) pulls reset mid-cycle and verifies outputs clear before the next edge.
    task automatic sweep(input int i, input int extra_at, input int abort_at, output int cycles);
        set_start(i, 1'b1);
        @(posedge clk);
        #1;
        set_start(i, 1'b0);
        cycles = 0;
        while (!is_done(i) && cycles < 400) begin
            set_start(i, (cycles == extra_at) ? 1'b1 : 1'b0);
            if (cycles == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("async_rst.busy",    int'(busy0), 0);
                check("async_rst.done",    int'(done0), 0);
                check("async_rst.err_cnt", int'(err0),  0);
                check("async_rst.dut_ops", int'({a0, b0, cin0}), 0);
                check("async_rst.vec_idx", int'(vec0),  0);
                set_start(i, 1'b0);
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                cycles = -1;
                return;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        set_start(i, 1'b0);
        if (cycles >= 400) check("sweep_timeout", 0, 1);
    endtask

    task automatic set_adder(input int i, input int am, input int xm);
        and_m[i] = am;
        xor_m[i] = xm;
    endtask

    initial begin
        int cyc;
        int am, xm, extra, abort_c;
        set_adder(0, full_mask(0), 0);
        set_adder(1, full_mask(1), 0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",    int'(busy0), 0);
        check("reset.pass",    int'(pass0), 0);
        check("reset.vec_idx", int'(vec0),  0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // W=2, SETTLE=3, ERR_W=2, s[0] stuck at 0: 32 vectors, count saturates at 3.
        set_adder(1, 3'b110, 0);
        sweep(1, -1, -1, cyc);
        check("w2.done_cycle", cyc, 128);
        check("w2.err_cnt",    int'(err1), 3);
        check("w2.pass",       int'(pass1), 0);

        // Correct adder.
        sweep(0, -1, -1, cyc);
        check("clean.done_cycle", cyc, 16);
        check("clean.pass",       int'(pass0), 1);
        check("clean.err_cnt",    int'(err0), 0);
        repeat (3) @(posedge clk);
        #1;

        // cout stuck at 0: vectors 3,5,6,7 fail.
        set_adder(0, 2'b01, 0);
        sweep(0, -1, -1, cyc);
        check("cout0.err_cnt", int'(err0), 4);
        check("cout0.pass",    int'(pass0), 0);
`ifdef ADD_BIST_CAPTURE_EN
        check("cout0.fail_vec", int'(fv0), 3);
        check("cout0.fail_rsp", int'(fr0), 0);
`endif

        // s inverted, then a clean rerun clears the count.
        set_adder(0, 2'b11, 2'b01);
        sweep(0, -1, -1, cyc);
        check("sinv.err_cnt", int'(err0), 8);
        check("sinv.pass",    int'(pass0), 0);
        set_adder(0, 2'b11, 0);
        sweep(0, -1, -1, cyc);
        check("rerun.err_cnt", int'(err0), 0);
        check("rerun.pass",    int'(pass0), 1);

        // Start while busy is ignored.
        sweep(0, 5, -1, cyc);
        check("restart_ignored.done_cycle", cyc, 16);

        // Reset mid-sweep with a faulty adder so err_cnt is non-zero when reset hits.
        set_adder(0, 2'b11, 2'b01);
        sweep(0, -1, 7, cyc);
        set_adder(0, 2'b11, 0);
        @(posedge clk);
        #1;
        sweep(0, -1, -1, cyc);
        check("post_reset.done_cycle", cyc, 16);
        check("post_reset.pass",       int'(pass0), 1);

        // Randomized faults, stray starts and occasional aborts.
        for (int it = 0; it < 25; it++) begin
            am = $urandom_range(0, 3);
            xm = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                am = 3;
                xm = 0;
            end
            extra   = $urandom_range(0, 20);
            abort_c = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : -1;
            set_adder(0, am, xm);
            sweep(0, extra, abort_c, cyc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
